// File: rtl/rom_bus_responder_pkg.sv
// Shared definitions for MCS-4 bus-side responders.
// Phase encoding counts A1..X3 so a plain increment walks the cycle.
package rom_bus_responder_pkg;

  typedef enum logic [2:0] {
    PH_A1,
    PH_A2,
    PH_A3,
    PH_M1,
    PH_M2,
    PH_X1,
    PH_X2,
    PH_X3
  } phase_e;

  localparam logic [3:0] OPA_WRR = 4'b0010;
  localparam logic [3:0] OPA_RDR = 4'b1010;

endpackage

// File: rtl/mcs4_phase_tracker.sv
// Tracks the 8-phase MCS-4 instruction cycle from clk2 edges.
// sync on a step forces A1, so a stray sync realigns within one step.
module mcs4_phase_tracker
  import rom_bus_responder_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clk2_i,
  input  logic   sync_i,
  output logic   step_o,
  output phase_e phase_o,
  output phase_e phase_nxt_o
);

  logic   clk2_q;
  phase_e phase_q;

  assign step_o      = clk2_i & ~clk2_q;
  assign phase_nxt_o = sync_i ? PH_A1 : phase_e'(phase_q + 3'd1);
  assign phase_o     = phase_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk2_q  <= 1'b0;
      phase_q <= PH_X3;
    end else begin
      clk2_q <= clk2_i;
      if (step_o) phase_q <= phase_nxt_o;
    end
  end

endmodule

// File: rtl/rom_bus_responder.sv
// ROM-side MCS-4 bus responder: address capture, OPR/OPA drive,
// and the SRC/WRR/RDR I/O port. All state moves on clk2 step events.
module rom_bus_responder
  import rom_bus_responder_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       sysclk,
  input  logic       poc,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  input  logic       cmrom,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  logic       step;
  phase_e     phase_q;
  phase_e     phase_nxt;
  logic [7:0] addr_q;
  logic [7:0] rom_addr_q;
  logic       rom_sel_q, rom_sel_d;
  logic       io_cyc_q;
  logic       io_sel_q;
  logic [3:0] opa_q;
  logic [3:0] io_out_q;
  logic [3:0] io_in_q;
  logic       data_oe_q, data_oe_d;
  logic       chip_hit;
  logic       rdr_hit;
  logic       wrr_hit;
  logic       unused_clk1;

  assign unused_clk1 = clk1;

  mcs4_phase_tracker u_phase (
    .clk_i       (sysclk),
    .rst_i       (poc),
    .clk2_i      (clk2),
    .sync_i      (sync),
    .step_o      (step),
    .phase_o     (phase_q),
    .phase_nxt_o (phase_nxt)
  );

  assign chip_hit = (data_in == CHIP_ID);
  assign rdr_hit  = io_cyc_q && io_sel_q && (opa_q == OPA_RDR);
  assign wrr_hit  = io_cyc_q && io_sel_q && (opa_q == OPA_WRR);

  // Drive enable is decided for the phase being entered.
  always_comb begin
    rom_sel_d = rom_sel_q;
    if (phase_q == PH_A1) rom_sel_d = 1'b0;
    if (phase_q == PH_A3) rom_sel_d = cmrom && chip_hit;
    data_oe_d = 1'b0;
    case (phase_nxt)
      PH_M1, PH_M2: data_oe_d = rom_sel_d;
      PH_X2:        data_oe_d = rdr_hit;
      default:      data_oe_d = 1'b0;
    endcase
  end

  always_comb begin
    data_out = 4'h0;
    if (data_oe_q) begin
      case (phase_q)
        PH_M1:   data_out = rom_data[7:4];
        PH_M2:   data_out = rom_data[3:0];
        PH_X2:   data_out = io_in_q;
        default: data_out = 4'h0;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      addr_q     <= 8'h00;
      rom_addr_q <= 8'h00;
      rom_sel_q  <= 1'b0;
      io_cyc_q   <= 1'b0;
      io_sel_q   <= 1'b0;
      opa_q      <= 4'h0;
      io_out_q   <= 4'h0;
      io_in_q    <= 4'h0;
      data_oe_q  <= 1'b0;
    end else if (step) begin
      data_oe_q <= data_oe_d;
      rom_sel_q <= rom_sel_d;
      case (phase_q)
        PH_A1: addr_q[3:0] <= data_in;
        PH_A2: addr_q[7:4] <= data_in;
        PH_A3: rom_addr_q  <= addr_q;
        PH_M2: begin
          if (cmrom) begin
            opa_q    <= data_in;
            io_cyc_q <= 1'b1;
          end
        end
        PH_X1: io_in_q <= io_in;
        PH_X2: begin
          // io_cyc separates SRC from the port write.
          if (cmrom && !io_cyc_q) io_sel_q <= chip_hit;
          else if (wrr_hit)       io_out_q <= data_in;
        end
        PH_X3: io_cyc_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign data_oe  = data_oe_q;
  assign rom_addr = rom_addr_q;
  assign io_out   = io_out_q;

endmodule

// File: tb/tb_rom_bus_responder.sv
// Directed and randomized bench for rom_bus_responder (CHIP_ID=3).
module tb_rom_bus_responder;

  localparam logic [3:0] CHIP = 4'h3;

  logic       sysclk = 1'b0;
  logic       poc, clk1, clk2, sync, cmrom;
  logic [3:0] data_in, data_out, io_in, io_out;
  logic       data_oe;
  logic [7:0] rom_addr, rom_data;
  logic [7:0] rom [256];

  int checks = 0;
  int failures = 0;

  // Reference model state; phase index 0..7 = A1..X3.
  int         m_ph;
  logic [7:0] m_addr, m_rom_addr;
  logic       m_rom_sel, m_io_cyc, m_io_sel;
  logic [3:0] m_opa, m_io_out, m_io_cap;

  rom_bus_responder #(.CHIP_ID(CHIP)) dut (
    .sysclk   (sysclk),
    .poc      (poc),
    .clk1     (clk1),
    .clk2     (clk2),
    .sync     (sync),
    .cmrom    (cmrom),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .io_in    (io_in),
    .io_out   (io_out)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_ph = 7;
    m_addr = 8'h00;
    m_rom_addr = 8'h00;
    m_rom_sel = 1'b0;
    m_io_cyc = 1'b0;
    m_io_sel = 1'b0;
    m_opa = 4'h0;
    m_io_out = 4'h0;
    m_io_cap = 4'h0;
  endtask

  task automatic mstep(input logic [3:0] d, input logic cm, input logic sy);
    case (m_ph)
      0: begin m_addr[3:0] = d; m_rom_sel = 1'b0; end
      1: m_addr[7:4] = d;
      2: begin m_rom_sel = cm && (d == CHIP); m_rom_addr = m_addr; end
      4: if (cm) begin m_opa = d; m_io_cyc = 1'b1; end
      5: m_io_cap = io_in;
      6: begin
        if (cm && !m_io_cyc) m_io_sel = (d == CHIP);
        else if (m_io_cyc && m_io_sel && m_opa == 4'h2) m_io_out = d;
      end
      7: m_io_cyc = 1'b0;
      default: ;
    endcase
    m_ph = sy ? 0 : (m_ph + 1) % 8;
  endtask

  function automatic logic e_oe();
    return ((m_ph == 3 || m_ph == 4) && m_rom_sel) ||
           (m_ph == 6 && m_io_cyc && m_io_sel && m_opa == 4'hA);
  endfunction

  function automatic logic [3:0] e_dout();
    logic [7:0] b;
    b = rom[m_rom_addr];
    if (!e_oe()) return 4'h0;
    if (m_ph == 3) return b[7:4];
    if (m_ph == 4) return b[3:0];
    return m_io_cap;
  endfunction

  // One phase: drive bus for the phase being left, pulse clk1 then clk2.
  task automatic st(input logic [3:0] d, input logic cm, input logic sy);
    mstep(d, cm, sy);
    data_in = d; cmrom = cm; sync = sy;
    clk1 = 1'b1; @(negedge sysclk);
    clk1 = 1'b0; clk2 = 1'b1; @(negedge sysclk);
    clk2 = 1'b0; sync = 1'b0; @(negedge sysclk);
    @(negedge sysclk);
    chk("data_oe", 8'(data_oe), 8'(e_oe()));
    chk("data_out", 8'(data_out), 8'(e_dout()));
    chk("rom_addr", rom_addr, m_rom_addr);
    chk("io_out", 8'(io_out), 8'(m_io_out));
  endtask

  task automatic cyc(input logic [3:0] a1, input logic [3:0] a2,
                     input logic [3:0] a3, input logic acm,
                     input logic [3:0] m2, input logic m2cm,
                     input logic [3:0] x2, input logic x2cm);
    st(a1, acm, 1'b0);
    st(a2, acm, 1'b0);
    st(a3, acm, 1'b0);
    st(4'h0, 1'b0, 1'b0);
    st(m2, m2cm, 1'b0);
    st(4'h0, 1'b0, 1'b0);
    st(x2, x2cm, 1'b0);
    st(4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] d;
    logic       sy;
    poc = 1'b1; clk1 = 1'b0; clk2 = 1'b0; sync = 1'b0;
    cmrom = 1'b0; data_in = 4'h0; io_in = 4'h0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom_data = 8'h00;
    mreset();
    repeat (3) @(negedge sysclk);
    chk("rst_oe", 8'(data_oe), 8'h00);
    chk("rst_dout", 8'(data_out), 8'h00);
    chk("rst_addr", rom_addr, 8'h00);
    chk("rst_io_out", 8'(io_out), 8'h00);
    poc = 1'b0;
    @(negedge sysclk);
    st(4'h0, 1'b0, 1'b1);

    // ROM fetch for chip 3 at 0xA5
    b = rom[8'hA5];
    st(4'h5, 1'b1, 1'b0);
    st(4'hA, 1'b1, 1'b0);
    st(4'h3, 1'b1, 1'b0);
    chk("fetch_addr", rom_addr, 8'hA5);
    chk("m1_oe", 8'(data_oe), 8'h01);
    chk("m1_opr", 8'(data_out), 8'(b[7:4]));
    st(4'h0, 1'b0, 1'b0);
    chk("m2_oe", 8'(data_oe), 8'h01);
    chk("m2_opa", 8'(data_out), 8'(b[3:0]));
    st(4'h0, 1'b0, 1'b0);
    chk("x1_oe", 8'(data_oe), 8'h00);
    st(4'h0, 1'b0, 1'b0);
    st(4'h0, 1'b0, 1'b0);
    st(4'h0, 1'b0, 1'b1);

    // Other chip selected: never drives
    st(4'h5, 1'b1, 1'b0);
    st(4'hA, 1'b1, 1'b0);
    st(4'h2, 1'b1, 1'b0);
    chk("nosel_m1_oe", 8'(data_oe), 8'h00);
    st(4'h0, 1'b0, 1'b0);
    chk("nosel_m2_oe", 8'(data_oe), 8'h00);
    repeat (3) st(4'h0, 1'b0, 1'b0);
    st(4'h0, 1'b0, 1'b1);

    // SRC chip 3, WRR 0xC; SRC chip 4, WRR ignored
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h3, 1'b1);
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 1'b1, 4'hC, 1'b0);
    chk("wrr_io_out", 8'(io_out), 8'h0C);
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h4, 1'b1);
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 1'b1, 4'h5, 1'b0);
    chk("wrr_unsel", 8'(io_out), 8'h0C);

    // RDR from chip 3 with io_in=9
    io_in = 4'h9;
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h3, 1'b1);
    repeat (4) st(4'h0, 1'b0, 1'b0);
    st(4'hA, 1'b1, 1'b0);
    chk("rdr_x1_oe", 8'(data_oe), 8'h00);
    st(4'h0, 1'b0, 1'b0);
    io_in = 4'h6;
    chk("rdr_x2_oe", 8'(data_oe), 8'h01);
    chk("rdr_x2_dout", 8'(data_out), 8'h09);
    st(4'h0, 1'b0, 1'b0);
    chk("rdr_x3_oe", 8'(data_oe), 8'h00);
    st(4'h0, 1'b0, 1'b1);

    // Stray sync at M1 realigns to A1
    st(4'h5, 1'b1, 1'b0);
    st(4'hA, 1'b1, 1'b0);
    st(4'h3, 1'b1, 1'b0);
    st(4'h0, 1'b0, 1'b1);
    chk("sync_a1_oe", 8'(data_oe), 8'h00);
    cyc(4'h7, 4'h1, 4'h3, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
    chk("sync_addr", rom_addr, 8'h17);

    // Reset during an M1 drive
    st(4'h5, 1'b1, 1'b0);
    st(4'hA, 1'b1, 1'b0);
    st(4'h3, 1'b1, 1'b0);
    chk("pre_rst_oe", 8'(data_oe), 8'h01);
    poc = 1'b1;
    #1;
    chk("async_rst_oe", 8'(data_oe), 8'h00);
    chk("async_rst_io", 8'(io_out), 8'h00);
    @(negedge sysclk);
    mreset();
    poc = 1'b0;
    @(negedge sysclk);
    st(4'h0, 1'b0, 1'b0);
    cyc(4'h5, 4'hA, 4'h3, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
    chk("post_rst_addr", rom_addr, 8'hA5);

    // Randomized phases against the model
    for (int n = 0; n < 1200; n++) begin
      io_in = 4'($urandom);
      d = 4'($urandom);
      if ((m_ph == 2 || m_ph == 6) && $urandom_range(0, 1) == 1) d = CHIP;
      if (m_ph == 4 && $urandom_range(0, 1) == 1)
        d = ($urandom_range(0, 1) == 1) ? 4'h2 : 4'hA;
      sy = (m_ph == 7) || ($urandom_range(0, 31) == 0);
      st(d, 1'($urandom), sy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_bus_responder.md
ROM_BUS_RESPONDER -- requirements
Module: rom_bus_responder

Interface
REQ-001 Parameter CHIP_ID, default 4'h0, meaning the ROM chip number matched on the address and SRC cycles.
REQ-002 sysclk  input  1  meaning single system clock; all state changes on its rising edge.
REQ-003 poc  input  1  meaning reset, asynchronous, active-high.
REQ-004 clk1  input  1  meaning phase-1 enable, sampled on sysclk.
REQ-005 clk2  input  1  meaning phase-2 enable, sampled on sysclk.
REQ-006 sync  input  1  meaning instruction-cycle sync from the CPU, high during X3.
REQ-007 cmrom  input  1  meaning CM-ROM command line from the CPU.
REQ-008 data_in  input  4  meaning data bus value from the pads.
REQ-009 data_out  output  4  meaning nibble this chip drives onto the data bus.
REQ-010 data_oe  output  1  meaning data_out is valid; the top level enables the pad driver with it.
REQ-011 rom_addr  output  8  meaning byte address into the ROM array.
REQ-012 rom_data  input  8  meaning ROM byte at rom_addr, valid one sysclk after rom_addr changes.
REQ-013 io_in  input  4  meaning I/O port input pins.
REQ-014 io_out  output  4  meaning registered I/O port output.

Function
- REQ-015 Step event = sysclk edge with clk2=1 and clk2 low on the previous sysclk (rising-edge detect, 1-bit history register).
- REQ-016 3-bit phase counter, order A1,A2,A3,M1,M2,X1,X2,X3; advances by one on each step event; X3 wraps to A1.
- REQ-017 Step event with sync=1 forces the next phase to A1 regardless of the current value; a stray sync therefore resynchronises within one step.
- REQ-018 On each step event, data_in is sampled for the phase being left: A1 -> addr[3:0], A2 -> addr[7:4], A3 -> chip nibble.
- REQ-019 On the A3 step: rom_sel <= cmrom && data_in==CHIP_ID; rom_addr <= the latched addr; rom_sel is cleared on the next A1 step.
- REQ-020 During M1, with rom_sel=1: data_oe=1 and data_out=rom_data[7:4] (OPR).
- REQ-021 During M2, with rom_sel=1: data_oe=1 and data_out=rom_data[3:0] (OPA).
- REQ-022 data_oe=0 in every other phase and whenever rom_sel=0.
- REQ-023 data_oe is registered and changes only on step events, so no glitches within a phase.
- REQ-024 On the M2 step with cmrom=1: latch opa=data_in and set io_cyc=1. This is an I/O instruction, and any chip observes it, not only the selected one; io_cyc is cleared at the X3 step.
- REQ-025 SRC: on the X2 step with cmrom=1 and io_cyc=0: io_sel <= data_in==CHIP_ID. io_sel holds until the next SRC.
- REQ-026 WRR: opa=4'b0010, io_cyc=1, io_sel=1 -> on the X2 step io_out <= data_in.
- REQ-027 RDR: opa=4'b1010, io_cyc=1, io_sel=1 -> data_oe=1 and data_out=io_in during X2; io_in is captured at the X1 step.
- REQ-028 Other opa values with io_cyc=1: no port action and no drive.
- REQ-029 Simultaneous ROM drive and RDR drive is impossible by phase; SRC and WRR cannot both occur in the same cycle because they are distinguished by io_cyc.

Reset
- REQ-030 While poc=1: phase=X3, rom_sel=0, io_sel=0, io_cyc=0, opa=0, io_out=4'h0, data_oe=0, data_out=4'h0, rom_addr=8'h00.
- REQ-031 Reset asserted mid-cycle clears data_oe asynchronously in the same sysclk.
- REQ-032 After poc falls, the first step event enters A1; the first sync realigns the phase if needed.

Structure
- REQ-033 The shared package holds the phase encoding enum and the I/O opcode constants (OPA_WRR=4'b0010, OPA_RDR=4'b1010).
- REQ-034 One sub-module, mcs4_phase_tracker: clk2 edge detect, sync realignment, phase counter. It is reusable by a future RAM-side responder.

Verification
- REQ-035 CHIP_ID=3, A1..A3 = 4'h5, 4'hA, 4'h3 with cmrom=1 -> rom_addr=8'hA5; M1/M2 drive rom_data[7:4], then [3:0], with data_oe=1.
- REQ-036 Same sequence with chip nibble 4'h2 -> data_oe=0 for the entire cycle.
- REQ-037 SRC: chip 3 on X2 with cmrom=1, then WRR (M2 opa=2, X2 data 4'hC) -> io_out=4'hC; a WRR after SRC selecting chip 4 leaves io_out unchanged.
- REQ-038 io_in=4'h9, SRC to chip 3, RDR -> data_out=4'h9 with data_oe=1 in X2 only.
- REQ-039 sync pulsed at M1 -> next phase is A1; a full cycle afterwards behaves as in REQ-035.
- REQ-040 poc asserted during M1 with data_oe=1 -> data_oe=0 immediately; io_out=0; normal operation from the first post-reset step.
